// File: rtl/jive_alu_seq_if.sv
// Request handshake between pipeline decode and the JiVe ALU micro-sequencer.
// The master presents one decoded operation; the slave signals when it can take it.
interface jive_alu_seq_if #(
    parameter int SHAMT_W = 5
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_kind;
    logic               req_store;
    logic [SHAMT_W-1:0] req_shamt;

    modport master (
        output req_valid,
        output req_kind,
        output req_store,
        output req_shamt,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_kind,
        input  req_store,
        input  req_shamt,
        output req_ready
    );
endinterface

// File: rtl/jive_alu_seq.sv
// Micro-sequencer for the JiVe 16-bit split ALU/address datapath: every operation runs
// an LSW half then an MSW half, shifts add shamt address-register shift cycles, then done.
module jive_alu_seq #(
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    jive_alu_seq_if.slave      req,
    input  logic               stall,
    output logic               msw_sel,
    output logic               wb_ena,
    output logic               sh_ena,
    output logic               upd_addr,
    output logic               upd_dout,
    output logic               wb_pc,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LSW,
        ST_MSW,
        ST_SHIFT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'b00,
        KIND_MEM   = 2'b01,
        KIND_JUMP  = 2'b10,
        KIND_SHIFT = 2'b11
    } kind_t;

    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;

    state_t             state, state_d;
    kind_t              kind_q, kind_d;
    logic               store_q, store_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [SHAMT_W-1:0] cnt, cnt_d;
    logic               accept;
    logic               addr_op;

    assign req.req_ready = ((state == ST_IDLE) || (state == ST_DONE)) && !stall;
    assign accept        = req.req_valid && req.req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            kind_q  <= KIND_ALU;
            store_q <= 1'b0;
            shamt_q <= CNT_ZERO;
            cnt     <= CNT_ZERO;
        end else begin
            state   <= state_d;
            kind_q  <= kind_d;
            store_q <= store_d;
            shamt_q <= shamt_d;
            cnt     <= cnt_d;
        end
    end

    // Next state; a stall freezes everything, and it also drops req_ready so no accept can occur.
    always_comb begin
        state_d = state;
        kind_d  = kind_q;
        store_d = store_q;
        shamt_d = shamt_q;
        cnt_d   = cnt;

        if (!stall) begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_d = ST_LSW;
                    end
                end
                ST_LSW: begin
                    state_d = ST_MSW;
                end
                ST_MSW: begin
                    if ((kind_q == KIND_SHIFT) && (shamt_q != CNT_ZERO)) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    cnt_d = cnt - CNT_ONE;
                    if (cnt > CNT_ONE) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state_d = ST_LSW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (accept) begin
                kind_d  = kind_t'(req.req_kind);
                store_d = req.req_store;
                shamt_d = req.req_shamt;
                cnt_d   = req.req_shamt;
            end
        end
    end

    assign addr_op = (kind_q == KIND_MEM) || (kind_q == KIND_JUMP) || (kind_q == KIND_SHIFT);

    // Strobes decode from state and the latched operation; msw_sel alone survives a stall.
    always_comb begin
        msw_sel  = 1'b0;
        wb_ena   = 1'b0;
        sh_ena   = 1'b0;
        upd_addr = 1'b0;
        upd_dout = 1'b0;
        wb_pc    = 1'b0;
        done     = 1'b0;
        busy     = (state != ST_IDLE);

        case (state)
            ST_LSW: begin
                wb_ena   = !stall;
                upd_addr = !stall && addr_op;
                upd_dout = !stall && (kind_q == KIND_MEM) && store_q;
                wb_pc    = !stall && (kind_q == KIND_JUMP);
            end
            ST_MSW: begin
                msw_sel  = 1'b1;
                wb_ena   = !stall;
                upd_addr = !stall && addr_op;
                upd_dout = !stall && (kind_q == KIND_MEM) && store_q;
            end
            ST_SHIFT: begin
                sh_ena = !stall;
            end
            ST_DONE: begin
                done = !stall;
            end
            default: begin
                msw_sel = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jive_alu_seq.sv
// Directed bench for jive_alu_seq: a per-cycle table of inputs and expected outputs,
// plus a long-shift sequence checking sh_ena count and done latency.
module tb_jive_alu_seq;

    localparam int SHAMT_W = 5;

    // Expected-output bit positions, packed as {ready,busy,done,msw,wb,sh,ua,ud,pc}.
    localparam logic [8:0] R = 9'h100;
    localparam logic [8:0] B = 9'h080;
    localparam logic [8:0] D = 9'h040;
    localparam logic [8:0] M = 9'h020;
    localparam logic [8:0] W = 9'h010;
    localparam logic [8:0] S = 9'h008;
    localparam logic [8:0] A = 9'h004;
    localparam logic [8:0] U = 9'h002;
    localparam logic [8:0] P = 9'h001;
    localparam logic [8:0] Z = 9'h000;

    typedef struct {
        string              name;
        logic               rst;
        logic               valid;
        logic [1:0]         kind;
        logic               store;
        logic [SHAMT_W-1:0] shamt;
        logic               stall;
        logic [8:0]         exp;
    } vec_t;

    logic clk;
    logic rst;
    logic stall;
    logic msw_sel, wb_ena, sh_ena, upd_addr, upd_dout, wb_pc, busy, done;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;
    logic excl_viol;

    jive_alu_seq_if #(.SHAMT_W(SHAMT_W)) req_if ();

    jive_alu_seq #(.SHAMT_W(SHAMT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req_if),
        .stall    (stall),
        .msw_sel  (msw_sel),
        .wb_ena   (wb_ena),
        .sh_ena   (sh_ena),
        .upd_addr (upd_addr),
        .upd_dout (upd_dout),
        .wb_pc    (wb_pc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_ena && sh_ena) excl_viol = 1'b1;
    end

    task automatic add(input string name, input logic r, input logic v, input logic [1:0] k,
                       input logic st, input int sh, input logic sl, input logic [8:0] e);
        vec_t x;
        x.name  = name;
        x.rst   = r;
        x.valid = v;
        x.kind  = k;
        x.store = st;
        x.shamt = SHAMT_W'(sh);
        x.stall = sl;
        x.exp   = e;
        vecs.push_back(x);
    endtask

    task automatic apply_stimulus(input vec_t x);
        @(posedge clk);
        #1;
        rst               = x.rst;
        req_if.req_valid  = x.valid;
        req_if.req_kind   = x.kind;
        req_if.req_store  = x.store;
        req_if.req_shamt  = x.shamt;
        stall             = x.stall;
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {req_if.req_ready, busy, done, msw_sel, wb_ena, sh_ena, upd_addr, upd_dout, wb_pc};
    endfunction

    initial begin
        int sh_cnt;
        int lat;
        int cyc;
        bit found;

        n_pass    = 0;
        n_total   = 0;
        excl_viol = 1'b0;
        rst       = 1'b1;
        stall     = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_kind  = 2'b00;
        req_if.req_store = 1'b0;
        req_if.req_shamt = '0;

        //  name          rst valid kind  st sh stall expected
        add("reset_idle", 0, 0, 2'b00, 0, 0, 0, R);
        add("alu_acc",    0, 1, 2'b00, 0, 0, 0, R);
        add("alu_lsw",    0, 0, 2'b00, 0, 0, 0, B|W);
        add("alu_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W);
        add("alu_done",   0, 0, 2'b00, 0, 0, 0, R|B|D);
        add("alu_idle",   0, 0, 2'b00, 0, 0, 0, R);
        add("st_acc",     0, 1, 2'b01, 1, 0, 0, R);
        add("st_lsw",     0, 1, 2'b00, 0, 0, 0, B|W|A|U);
        add("st_msw",     0, 1, 2'b00, 0, 0, 0, B|M|W|A|U);
        add("st_done_b2b",0, 1, 2'b00, 0, 0, 0, R|B|D);
        add("b2b_lsw",    0, 0, 2'b00, 0, 0, 0, B|W);
        add("b2b_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W);
        add("b2b_done",   0, 0, 2'b00, 0, 0, 0, R|B|D);
        add("b2b_idle",   0, 0, 2'b00, 0, 0, 0, R);
        add("sh5_acc",    0, 1, 2'b11, 0, 5, 0, R);
        add("sh5_lsw",    0, 0, 2'b00, 0, 0, 0, B|W|A);
        add("sh5_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W|A);
        for (int i = 0; i < 5; i++) add($sformatf("sh5_shift%0d", i), 0, 0, 2'b00, 0, 0, 0, B|S);
        add("sh5_done",   0, 1, 2'b11, 0, 0, 0, R|B|D);
        add("sh0_lsw",    0, 0, 2'b00, 0, 0, 0, B|W|A);
        add("sh0_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W|A);
        add("sh0_done",   0, 0, 2'b00, 0, 0, 0, R|B|D);
        add("sh0_idle",   0, 0, 2'b00, 0, 0, 0, R);
        add("jmp_acc",    0, 1, 2'b10, 0, 0, 0, R);
        add("jmp_lsw",    0, 0, 2'b00, 0, 0, 0, B|W|A|P);
        add("jmp_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W|A);
        add("jmp_done",   0, 0, 2'b00, 0, 0, 0, R|B|D);
        add("jmp_idle",   0, 0, 2'b00, 0, 0, 0, R);
        add("sh3_acc",    0, 1, 2'b11, 0, 3, 0, R);
        add("sh3_lsw",    0, 0, 2'b00, 0, 0, 0, B|W|A);
        add("sh3_msw",    0, 0, 2'b00, 0, 0, 0, B|M|W|A);
        add("sh3_shift0", 0, 0, 2'b00, 0, 0, 0, B|S);
        add("sh3_stall0", 0, 0, 2'b00, 0, 0, 1, B);
        add("sh3_stall1", 0, 0, 2'b00, 0, 0, 1, B);
        add("sh3_shift1", 0, 0, 2'b00, 0, 0, 0, B|S);
        add("sh3_shift2", 0, 0, 2'b00, 0, 0, 0, B|S);
        add("sh3_done_st",0, 0, 2'b00, 0, 0, 1, B);
        add("sh3_done",   0, 0, 2'b00, 0, 0, 0, R|B|D);
        add("idle_stall", 0, 1, 2'b00, 0, 0, 1, Z);
        add("idle_noacc", 0, 0, 2'b00, 0, 0, 0, R);
        add("ld_acc",     0, 1, 2'b01, 0, 0, 0, R);
        add("ld_lsw",     0, 0, 2'b00, 0, 0, 0, B|W|A);
        add("ld_msw_st",  0, 0, 2'b00, 0, 0, 1, B|M);
        add("ld_msw_rst", 1, 0, 2'b00, 0, 0, 0, B|M|W|A);
        add("rst_idle",   0, 0, 2'b00, 0, 0, 0, R);
        add("rst_idle2",  0, 0, 2'b00, 0, 0, 0, R);

        repeat (2) @(posedge clk);
        $display("[TB] applying %0d table vectors", vecs.size());

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #3;
            check_output(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end

        // Longest shift: 31 sh_ena cycles, done 34 cycles after the accept cycle.
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b1;
        req_if.req_kind  = 2'b11;
        req_if.req_shamt = 5'd31;
        @(posedge clk);
        #1;
        req_if.req_valid = 1'b0;
        req_if.req_shamt = '0;
        sh_cnt = 0;
        lat    = 0;
        cyc    = 1;
        found  = 1'b0;
        while (!found && cyc < 60) begin
            #3;
            if (sh_ena) sh_cnt++;
            if (done) begin
                lat   = cyc;
                found = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("sh31_done_seen", 32'(found), 32'd1);
        check_output("sh31_sh_count", 32'(sh_cnt), 32'd31);
        check_output("sh31_latency", 32'(lat), 32'd34);
        #3;
        check_output("sh31_idle", 32'(outs()), 32'(R));

        check_output("wb_sh_exclusive", 32'(excl_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
